// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: in-order allocation of predicted branches, out-of-order
// resolution from execute, in-order retirement with predictor update and
// fetch redirect on mispredict.
module branch_resolve_queue #(
    parameter int unsigned BRQ_SIZE = 8,
    parameter int unsigned OBQ_SIZE = 16,
    parameter int unsigned IDX_W    = $clog2(OBQ_SIZE) + 1
) (
    input  logic                          clock,
    input  logic                          reset,

    input  logic                          pred_valid,
    input  logic [31:0]                   pred_pc,
    input  logic                          pred_taken,
    input  logic [31:0]                   pred_target,
    input  logic [IDX_W-1:0]              pred_index,
    output logic                          pred_ready,
    output logic [$clog2(BRQ_SIZE)-1:0]   alloc_tag,

    input  logic                          ex_valid,
    input  logic [$clog2(BRQ_SIZE)-1:0]   ex_tag,
    input  logic                          ex_taken,
    input  logic [31:0]                   ex_target,

    output logic                          rt_en_branch,
    output logic                          rt_branch_taken,
    output logic                          rt_prediction_correct,
    output logic [31:0]                   rt_pc,
    output logic [31:0]                   rt_calculated_pc,
    output logic [IDX_W-1:0]              rt_branch_index,

    output logic                          redirect_valid,
    output logic [31:0]                   redirect_pc,

    output logic [$clog2(BRQ_SIZE):0]     count
);

    localparam int unsigned PTR_W = $clog2(BRQ_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0]      pc;
        logic             pred_taken;
        logic [31:0]      pred_target;
        logic [IDX_W-1:0] index;
        logic             act_taken;
        logic [31:0]      act_target;
    } entry_t;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      head_q, head_d;
    logic [CNT_W-1:0]      tail_q, tail_d;
    logic [BRQ_SIZE-1:0]   valid_q, valid_d;
    logic [BRQ_SIZE-1:0]   resolved_q, resolved_d;
    entry_t                ent_q [BRQ_SIZE];
    entry_t                ent_d [BRQ_SIZE];

    logic                  rt_en_q, rt_en_d;
    logic                  rt_taken_q, rt_taken_d;
    logic                  rt_correct_q, rt_correct_d;
    logic [31:0]           rt_pc_q, rt_pc_d;
    logic [31:0]           rt_calc_q, rt_calc_d;
    logic [IDX_W-1:0]      rt_index_q, rt_index_d;
    logic                  redirect_valid_q, redirect_valid_d;
    logic [31:0]           redirect_pc_q, redirect_pc_d;

    logic [PTR_W-1:0]      head_slot;
    logic [PTR_W-1:0]      tail_slot;
    logic                  full;
    logic                  alloc_fire;
    entry_t                head_ent;
    logic                  retire;
    logic                  head_correct;
    logic [31:0]           head_calc_pc;
    logic                  mispredict;

    // Pointer decode, occupancy and allocation handshake
    always_comb begin
        head_slot  = head_q[PTR_W-1:0];
        tail_slot  = tail_q[PTR_W-1:0];
        full       = (head_slot == tail_slot) && (head_q[PTR_W] != tail_q[PTR_W]);
        pred_ready = !full && (state_q == ST_RUN);
        alloc_fire = pred_valid && pred_ready;
        alloc_tag  = tail_slot;
        count      = CNT_W'(tail_q - head_q);
    end

    // Head-of-queue retire decision and outcome evaluation
    always_comb begin
        head_ent     = ent_q[head_slot];
        retire       = (state_q == ST_RUN) && valid_q[head_slot] && resolved_q[head_slot];
        head_calc_pc = head_ent.act_taken ? head_ent.act_target : (head_ent.pc + 32'd4);
        head_correct = (head_ent.act_taken == head_ent.pred_taken) &&
                       (!head_ent.act_taken || (head_ent.act_target == head_ent.pred_target));
        mispredict   = retire && !head_correct;
    end

    // Next-state: resolution writes, allocation, retire and recovery flush
    always_comb begin
        state_d          = state_q;
        head_d           = head_q;
        tail_d           = tail_q;
        valid_d          = valid_q;
        resolved_d       = resolved_q;
        ent_d            = ent_q;
        rt_en_d          = 1'b0;
        rt_taken_d       = rt_taken_q;
        rt_correct_d     = rt_correct_q;
        rt_pc_d          = rt_pc_q;
        rt_calc_d        = rt_calc_q;
        rt_index_d       = rt_index_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;

        // Resolution only lands on live entries; anything else is a stray write
        if ((state_q == ST_RUN) && ex_valid && valid_q[ex_tag]) begin
            ent_d[ex_tag].act_taken  = ex_taken;
            ent_d[ex_tag].act_target = ex_target;
            resolved_d[ex_tag]       = 1'b1;
        end

        // Allocation at tail is dropped when the head flushes the queue this cycle
        if (alloc_fire && !mispredict) begin
            ent_d[tail_slot].pc          = pred_pc;
            ent_d[tail_slot].pred_taken  = pred_taken;
            ent_d[tail_slot].pred_target = pred_target;
            ent_d[tail_slot].index       = pred_index;
            ent_d[tail_slot].act_taken   = 1'b0;
            ent_d[tail_slot].act_target  = 32'd0;
            valid_d[tail_slot]           = 1'b1;
            resolved_d[tail_slot]        = 1'b0;
            tail_d                       = tail_q + CNT_W'(1);
        end

        if (retire) begin
            rt_en_d      = 1'b1;
            rt_taken_d   = head_ent.act_taken;
            rt_correct_d = head_correct;
            rt_pc_d      = head_ent.pc;
            rt_calc_d    = head_calc_pc;
            rt_index_d   = head_ent.index;
            if (mispredict) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = head_calc_pc;
                valid_d          = '0;
                resolved_d       = '0;
                head_d           = '0;
                tail_d           = '0;
                state_d          = ST_RECOVER;
            end else begin
                valid_d[head_slot]    = 1'b0;
                resolved_d[head_slot] = 1'b0;
                head_d                = head_q + CNT_W'(1);
            end
        end

        // Recovery lasts exactly one cycle
        if (state_q == ST_RECOVER) begin
            state_d = ST_RUN;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_RUN;
            head_q           <= '0;
            tail_q           <= '0;
            valid_q          <= '0;
            resolved_q       <= '0;
            for (int i = 0; i < int'(BRQ_SIZE); i++) begin
                ent_q[i] <= '0;
            end
            rt_en_q          <= 1'b0;
            rt_taken_q       <= 1'b0;
            rt_correct_q     <= 1'b0;
            rt_pc_q          <= '0;
            rt_calc_q        <= '0;
            rt_index_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            valid_q          <= valid_d;
            resolved_q       <= resolved_d;
            ent_q            <= ent_d;
            rt_en_q          <= rt_en_d;
            rt_taken_q       <= rt_taken_d;
            rt_correct_q     <= rt_correct_d;
            rt_pc_q          <= rt_pc_d;
            rt_calc_q        <= rt_calc_d;
            rt_index_q       <= rt_index_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Registered outputs
    always_comb begin
        rt_en_branch          = rt_en_q;
        rt_branch_taken       = rt_taken_q;
        rt_prediction_correct = rt_correct_q;
        rt_pc                 = rt_pc_q;
        rt_calculated_pc      = rt_calc_q;
        rt_branch_index       = rt_index_q;
        redirect_valid        = redirect_valid_q;
        redirect_pc           = redirect_pc_q;
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Testbench for branch_resolve_queue: vector table plus multi-cycle sequences.
module tb_branch_resolve_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [4:0]  pred_index;
    logic        pred_ready;
    logic [2:0]  alloc_tag;
    logic        ex_valid;
    logic [2:0]  ex_tag;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        rt_en_branch;
    logic        rt_branch_taken;
    logic        rt_prediction_correct;
    logic [31:0] rt_pc;
    logic [31:0] rt_calculated_pc;
    logic [4:0]  rt_branch_index;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  count;

    int n_total = 0;
    int n_pass  = 0;

    branch_resolve_queue dut (
        .clock                 (clock),
        .reset                 (reset),
        .pred_valid            (pred_valid),
        .pred_pc               (pred_pc),
        .pred_taken            (pred_taken),
        .pred_target           (pred_target),
        .pred_index            (pred_index),
        .pred_ready            (pred_ready),
        .alloc_tag             (alloc_tag),
        .ex_valid              (ex_valid),
        .ex_tag                (ex_tag),
        .ex_taken              (ex_taken),
        .ex_target             (ex_target),
        .rt_en_branch          (rt_en_branch),
        .rt_branch_taken       (rt_branch_taken),
        .rt_prediction_correct (rt_prediction_correct),
        .rt_pc                 (rt_pc),
        .rt_calculated_pc      (rt_calculated_pc),
        .rt_branch_index       (rt_branch_index),
        .redirect_valid        (redirect_valid),
        .redirect_pc           (redirect_pc),
        .count                 (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rst, pv, ppc, pt, ptg, pidx;
        logic [31:0] ev, etag, et, etg;
        logic [31:0] rdy, cnt, tag, en, tk, ok, pc, cpc, idx, rv, rpc;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        pred_valid  = 1'b0;
        pred_pc     = '0;
        pred_taken  = 1'b0;
        pred_target = '0;
        pred_index  = '0;
        ex_valid    = 1'b0;
        ex_tag      = '0;
        ex_taken    = 1'b0;
        ex_target   = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic alloc(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic [4:0] ix);
        pred_valid  = 1'b1;
        pred_pc     = pc;
        pred_taken  = tk;
        pred_target = tg;
        pred_index  = ix;
    endtask

    task automatic resolve(input logic [2:0] tg, input logic tk, input logic [31:0] tgt);
        ex_valid  = 1'b1;
        ex_tag    = tg;
        ex_taken  = tk;
        ex_target = tgt;
    endtask

    initial begin
        reset = 1'b1;
        idle();

        //          rst pv ppc          pt ptg      pidx ev etag et etg       rdy cnt tag en tk ok pc            cpc      idx rv rpc
        vecs[0]  = '{1, 0, 0,           0, 0,       0,   0, 0,   0, 0,        1,  0,  0,  0, 0, 0, 0,            0,       0,  0, 0};
        vecs[1]  = '{0, 1, 'h100,       1, 'h200,   3,   0, 0,   0, 0,        1,  1,  1,  0, 0, 0, 0,            0,       0,  0, 0};
        vecs[2]  = '{0, 0, 0,           0, 0,       0,   1, 0,   1, 'h200,    1,  1,  1,  0, 0, 0, 0,            0,       0,  0, 0};
        vecs[3]  = '{0, 0, 0,           0, 0,       0,   0, 0,   0, 0,        1,  0,  1,  1, 1, 1, 'h100,        'h200,   3,  0, 0};
        vecs[4]  = '{0, 0, 0,           0, 0,       0,   0, 0,   0, 0,        1,  0,  1,  0, 1, 1, 'h100,        'h200,   3,  0, 0};
        vecs[5]  = '{0, 1, 'h40,        1, 'h80,    5,   0, 0,   0, 0,        1,  1,  2,  0, 1, 1, 'h100,        'h200,   3,  0, 0};
        vecs[6]  = '{0, 0, 0,           0, 0,       0,   1, 1,   0, 'h1234,   1,  1,  2,  0, 1, 1, 'h100,        'h200,   3,  0, 0};
        vecs[7]  = '{0, 1, 'h999,       0, 'h99d,   6,   0, 0,   0, 0,        0,  0,  0,  1, 0, 0, 'h40,         'h44,    5,  1, 'h44};
        vecs[8]  = '{0, 1, 'h777,       0, 'h77b,   4,   0, 0,   0, 0,        1,  0,  0,  0, 0, 0, 'h40,         'h44,    5,  0, 'h44};
        vecs[9]  = '{0, 0, 0,           0, 0,       0,   1, 3,   1, 'h500,    1,  0,  0,  0, 0, 0, 'h40,         'h44,    5,  0, 'h44};
        vecs[10] = '{0, 1, 'h300,       0, 'h304,   1,   0, 0,   0, 0,        1,  1,  1,  0, 0, 0, 'h40,         'h44,    5,  0, 'h44};
        vecs[11] = '{0, 0, 0,           0, 0,       0,   1, 0,   0, 0,        1,  1,  1,  0, 0, 0, 'h40,         'h44,    5,  0, 'h44};
        vecs[12] = '{0, 0, 0,           0, 0,       0,   0, 0,   0, 0,        1,  0,  1,  1, 0, 1, 'h300,        'h304,   1,  0, 'h44};
        vecs[13] = '{0, 1, 'hFFFFFFFC,  0, 0,       7,   0, 0,   0, 0,        1,  1,  2,  0, 0, 1, 'h300,        'h304,   1,  0, 'h44};
        vecs[14] = '{0, 0, 0,           0, 0,       0,   1, 1,   0, 'hABC,    1,  1,  2,  0, 0, 1, 'h300,        'h304,   1,  0, 'h44};
        vecs[15] = '{0, 0, 0,           0, 0,       0,   0, 0,   0, 0,        1,  0,  2,  1, 0, 1, 'hFFFFFFFC,   0,       7,  0, 'h44};
        vecs[16] = '{0, 1, 'h500,       1, 'h600,   2,   0, 0,   0, 0,        1,  1,  3,  0, 0, 1, 'hFFFFFFFC,   0,       7,  0, 'h44};
        vecs[17] = '{0, 0, 0,           0, 0,       0,   1, 2,   1, 'h700,    1,  1,  3,  0, 0, 1, 'hFFFFFFFC,   0,       7,  0, 'h44};
        vecs[18] = '{0, 0, 0,           0, 0,       0,   0, 0,   0, 0,        0,  0,  0,  1, 1, 0, 'h500,        'h700,   2,  1, 'h700};
        vecs[19] = '{0, 0, 0,           0, 0,       0,   0, 0,   0, 0,        1,  0,  0,  0, 1, 0, 'h500,        'h700,   2,  0, 'h700};

        // Table-driven vectors: inputs held for one cycle, outputs checked after the edge
        for (int i = 0; i < 20; i++) begin
            reset       = vecs[i].rst[0];
            pred_valid  = vecs[i].pv[0];
            pred_pc     = vecs[i].ppc;
            pred_taken  = vecs[i].pt[0];
            pred_target = vecs[i].ptg;
            pred_index  = vecs[i].pidx[4:0];
            ex_valid    = vecs[i].ev[0];
            ex_tag      = vecs[i].etag[2:0];
            ex_taken    = vecs[i].et[0];
            ex_target   = vecs[i].etg;
            tick();
            chk($sformatf("v%0d.ready", i),   32'(pred_ready),            vecs[i].rdy);
            chk($sformatf("v%0d.count", i),   32'(count),                 vecs[i].cnt);
            chk($sformatf("v%0d.tag", i),     32'(alloc_tag),             vecs[i].tag);
            chk($sformatf("v%0d.rt_en", i),   32'(rt_en_branch),          vecs[i].en);
            chk($sformatf("v%0d.rt_tk", i),   32'(rt_branch_taken),       vecs[i].tk);
            chk($sformatf("v%0d.rt_ok", i),   32'(rt_prediction_correct), vecs[i].ok);
            chk($sformatf("v%0d.rt_pc", i),   rt_pc,                      vecs[i].pc);
            chk($sformatf("v%0d.rt_cpc", i),  rt_calculated_pc,           vecs[i].cpc);
            chk($sformatf("v%0d.rt_idx", i),  32'(rt_branch_index),       vecs[i].idx);
            chk($sformatf("v%0d.redir", i),   32'(redirect_valid),        vecs[i].rv);
            chk($sformatf("v%0d.redir_pc", i), redirect_pc,               vecs[i].rpc);
        end
        reset = 1'b0;
        idle();

        // Fill, overflow attempt, reverse-order resolution, in-order retire
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill%0d.tag", i), 32'(alloc_tag), 32'(i));
            alloc(32'h1000 + 32'(i * 16), 1'b0, 32'h1004 + 32'(i * 16), 5'(i));
            tick();
        end
        chk("full.ready", 32'(pred_ready), 32'd0);
        chk("full.count", 32'(count), 32'd8);
        alloc(32'hDEAD0000, 1'b1, 32'h0, 5'd9);
        tick();
        chk("full.ninth_count", 32'(count), 32'd8);
        chk("full.ninth_tag", 32'(alloc_tag), 32'd0);
        idle();
        for (int k = 7; k >= 0; k--) begin
            resolve(3'(k), 1'b0, 32'h0);
            tick();
            chk($sformatf("rev%0d.no_rt", k), 32'(rt_en_branch), 32'd0);
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) alloc(32'hBEEF0000, 1'b0, 32'h0, 5'd1);
            tick();
            idle();
            chk($sformatf("ret%0d.en", i),    32'(rt_en_branch),          32'd1);
            chk($sformatf("ret%0d.pc", i),    rt_pc,                      32'h1000 + 32'(i * 16));
            chk($sformatf("ret%0d.idx", i),   32'(rt_branch_index),       32'(i));
            chk($sformatf("ret%0d.ok", i),    32'(rt_prediction_correct), 32'd1);
            chk($sformatf("ret%0d.count", i), 32'(count),                 32'(7 - i));
        end
        tick();
        chk("drain.en", 32'(rt_en_branch), 32'd0);

        // Mispredict at head with younger resolved entries behind it
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc(32'h2000 + 32'(i * 4), 1'b0, 32'h2004 + 32'(i * 4), 5'(i));
            tick();
        end
        idle();
        for (int k = 5; k >= 1; k--) begin
            resolve(3'(k), 1'b0, 32'h0);
            tick();
            chk($sformatf("young%0d.no_rt", k), 32'(rt_en_branch), 32'd0);
        end
        resolve(3'd0, 1'b1, 32'h900);
        tick();
        idle();
        chk("mp.latency", 32'(rt_en_branch), 32'd0);
        tick();
        chk("mp.en", 32'(rt_en_branch), 32'd1);
        chk("mp.ok", 32'(rt_prediction_correct), 32'd0);
        chk("mp.pc", rt_pc, 32'h2000);
        chk("mp.redir", 32'(redirect_valid), 32'd1);
        chk("mp.redir_pc", redirect_pc, 32'h900);
        chk("mp.count", 32'(count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("mp.quiet%0d", i), 32'(rt_en_branch), 32'd0);
        end
        chk("mp.tag", 32'(alloc_tag), 32'd0);
        chk("mp.ready", 32'(pred_ready), 32'd1);

        // Steady alloc+resolve+retire across pointer wrap
        do_reset();
        for (int n = 0; n < 20; n++) begin
            alloc(32'h3000 + 32'(n * 4), 1'b0, 32'h3004 + 32'(n * 4), 5'(n % 8));
            if (n >= 1) resolve(3'((n - 1) % 8), 1'b0, 32'h0);
            tick();
            if (n >= 1) chk($sformatf("wrap%0d.count", n), 32'(count), 32'd2);
            chk($sformatf("wrap%0d.tag", n), 32'(alloc_tag), 32'((n + 1) % 8));
            if (n >= 2) begin
                chk($sformatf("wrap%0d.ready", n), 32'(pred_ready), 32'd1);
                chk($sformatf("wrap%0d.en", n), 32'(rt_en_branch), 32'd1);
                chk($sformatf("wrap%0d.pc", n), rt_pc, 32'h3000 + 32'((n - 2) * 4));
            end
        end
        idle();

        // Reset asserted during RECOVER, with stray inputs that cycle
        do_reset();
        alloc(32'h40, 1'b1, 32'h80, 5'd5);
        tick();
        idle();
        resolve(3'd0, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        chk("rec.redir", 32'(redirect_valid), 32'd1);
        reset = 1'b1;
        alloc(32'h60, 1'b1, 32'h64, 5'd2);
        resolve(3'd0, 1'b1, 32'h88);
        tick();
        reset = 1'b0;
        idle();
        chk("rst.rt_en",  32'(rt_en_branch),          32'd0);
        chk("rst.rt_tk",  32'(rt_branch_taken),       32'd0);
        chk("rst.rt_ok",  32'(rt_prediction_correct), 32'd0);
        chk("rst.rt_pc",  rt_pc,                      32'd0);
        chk("rst.rt_cpc", rt_calculated_pc,           32'd0);
        chk("rst.rt_idx", 32'(rt_branch_index),       32'd0);
        chk("rst.redir",  32'(redirect_valid),        32'd0);
        chk("rst.rpc",    redirect_pc,                32'd0);
        chk("rst.count",  32'(count),                 32'd0);
        chk("rst.ready",  32'(pred_ready),            32'd1);
        chk("rst.tag",    32'(alloc_tag),             32'd0);

        // Reset wins over a retire that would happen the same cycle
        alloc(32'h50, 1'b0, 32'h54, 5'd3);
        tick();
        idle();
        resolve(3'd0, 1'b0, 32'h0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstret.en",    32'(rt_en_branch), 32'd0);
        chk("rstret.pc",    rt_pc,             32'd0);
        chk("rstret.count", 32'(count),        32'd0);
        tick();
        chk("rstret.after", 32'(rt_en_branch), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter BRQ_SIZE, default 8 (power of 2, >=2), meaning number of in-flight branch entries.
REQ-002 SHALL have parameter IDX_W, default $clog2(`OBQ_SIZE)+1, meaning width of the predictor OBQ index carried per entry.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port pred_valid, input, 1, predictor issuing a branch this cycle.
REQ-006 SHALL have port pred_pc, input, 32, PC of the predicted branch.
REQ-007 SHALL have port pred_taken, input, 1, predicted direction.
REQ-008 SHALL have port pred_target, input, 32, predicted next PC.
REQ-009 SHALL have port pred_index, input, IDX_W, predictor OBQ index.
REQ-010 SHALL have port pred_ready, output, 1, entry available; allocation occurs only when pred_valid & pred_ready.
REQ-011 SHALL have port alloc_tag, output, $clog2(BRQ_SIZE), slot given to the branch allocated this cycle (combinational, equals tail slot).
REQ-012 SHALL have ports ex_valid (1), ex_tag ($clog2(BRQ_SIZE)), ex_taken (1), ex_target (32), all inputs: execute-stage resolution of one branch.
REQ-013 SHALL have outputs rt_en_branch (1), rt_branch_taken (1), rt_prediction_correct (1), rt_pc (32), rt_calculated_pc (32), rt_branch_index (IDX_W): retire-side predictor update, registered.
REQ-014 SHALL have outputs redirect_valid (1) and redirect_pc (32): fetch redirect on mispredict, registered.
REQ-015 SHALL have output count ($clog2(BRQ_SIZE)+1): number of valid entries.

Function
REQ-016 SHALL hold entries in a circular FIFO with head/tail pointers carrying one extra wrap bit; full = slot bits equal and wrap bits differ; empty = pointers equal.
REQ-017 SHALL set pred_ready = !full and state==RUN; no allocation when full, even if the head retires that same cycle.
REQ-018 SHALL on allocation store pc, taken, target, index, set valid=1, resolved=0, advance tail by 1 with wrap.
REQ-019 SHALL on ex_valid write ex_taken/ex_target into entry ex_tag and set resolved=1 only if that entry is valid; writes to invalid entries and writes in RECOVER SHALL be ignored.
REQ-020 SHALL resolve out of order but retire strictly in order: at most one retire per cycle, from head, only when head entry is valid and resolved before the clock edge (resolution-to-retire latency minimum 1 cycle).
REQ-021 SHALL on retire drive, next cycle for one cycle, rt_en_branch=1, rt_pc=entry pc, rt_branch_index=entry index, rt_branch_taken=actual taken, rt_calculated_pc = actual target if taken else pc+4 (mod 2^32).
REQ-022 SHALL compute rt_prediction_correct = (actual taken == predicted taken) and, when taken, (actual target == predicted target).
REQ-023 SHALL when retiring a correct prediction clear the head entry valid bit and advance head.
REQ-024 SHALL when retiring a mispredicted entry: assert redirect_valid=1 with redirect_pc=rt_calculated_pc in the same cycle as rt_en_branch; clear all valid bits; set head=tail=0; enter RECOVER; ignore any allocation presented that cycle.
REQ-025 SHALL implement states RUN and RECOVER: RUN->RECOVER on mispredict retire; RECOVER->RUN unconditionally after one cycle; in RECOVER pred_ready=0, no retire, ex writes dropped.
REQ-026 SHALL deassert rt_en_branch and redirect_valid in every cycle without a retire; other rt_* outputs hold last value.
REQ-027 SHALL allow allocation and retire in the same cycle when not full; count then unchanged.

Reset
REQ-028 SHALL on reset: state=RUN, head=tail=0, all valid/resolved=0, count=0, rt_en_branch=0, rt_branch_taken=0, rt_prediction_correct=0, rt_pc=0, rt_calculated_pc=0, rt_branch_index=0, redirect_valid=0, redirect_pc=0.
REQ-029 SHALL let reset override all other activity, including mid-RECOVER or a same-cycle retire; inputs that cycle are discarded.

Verification
REQ-030 Allocate pc=0x100, taken=1, target=0x200, index=3; resolve tag 0 taken, target 0x200 -> next cycle retire: rt_en_branch=1, rt_prediction_correct=1, rt_calculated_pc=0x200, rt_branch_index=3, redirect_valid=0.
REQ-031 Allocate pc=0x40 predicted taken to 0x80; resolve not taken -> rt_prediction_correct=0, rt_calculated_pc=0x44, redirect_valid=1, redirect_pc=0x44, count=0, pred_ready=0 for one cycle, then 1.
REQ-032 Fill 8 entries -> pred_ready=0, count=8; 9th pred_valid ignored; resolve tags 7..0 in reverse order -> retires emerge in order tag 0..7, one per cycle.
REQ-033 Mispredict at head with 5 younger entries resolved -> only head retires; younger entries never drive rt_en_branch; subsequent alloc_tag=0.
REQ-034 ex_valid to an empty slot, and reset asserted during RECOVER -> no state change from the stray write; all outputs at reset values the cycle after reset.
REQ-035 Run tail past wrap (16 alloc/retire pairs, simultaneous alloc+retire each cycle) -> count stays constant, no spurious full/empty.
